// File: rtl/trans_test_echo.sv
// AD-side loopback responder for the DE1 link test.
//
// Words arriving on the DE1 -> AD serial link are captured by spi_slave, XORed with ECHO_MASK
// and returned on the AD -> DE1 link through spi_master. One word is in flight at a time.
// Words whose return path stays busy for TIMEOUT_CYC cycles are dropped and counted.
//
// Serial frame (both links): SS low for the frame, 64 bits MSB first, SD stable across the
// SCK rising edge. After a frame the receiver acknowledges on SACK. spi_slave drives SACK high
// while it holds an unconsumed word; spi_master stays busy until it sees SACK high.
//
// trans_test_echo ports:
//   CLK, RESET_N                    clock, async active-low reset
//   SPI_RX_SS/SCK/SD, SPI_RX_SACK   DE1 -> AD link (into spi_slave)
//   SPI_TX_SS/SCK/SD, SPI_TX_SACK   AD -> DE1 link (out of spi_master)
//   WORD_CNT, DROP_CNT              echoed / dropped word counters (wrap)
//   LAST_WORD                       last word handed to the master, after masking
//   TIMEOUT                         sticky, set on the first dropped word

// Serial receiver: synchronises the link into CLK and presents one 64-bit word at a time.
module spi_slave (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ss_i,
  input  logic        sck_i,
  input  logic        sd_i,
  output logic        sack_o,
  output logic [63:0] data_o,
  output logic        valid_o,
  input  logic        rd_i
);
  // [1] is the synchronised value, [2] the previous one for edge detection
  logic [2:0]  ss_q, sck_q;
  logic [1:0]  sd_q;
  logic [63:0] shift_q, shift_d, data_q, data_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic        sck_rise, frame_start, frame_end;

  assign sck_rise    = sck_q[1] & ~sck_q[2];
  assign frame_start = ~ss_q[1] & ss_q[2];
  assign frame_end   = ss_q[1] & ~ss_q[2];

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (rd_i) valid_d = 1'b0;
    if (frame_start) begin
      cnt_d = '0;
    end else if (!ss_q[1] && sck_rise) begin
      shift_d = {shift_q[62:0], sd_q[1]};
      if (cnt_q != 7'd64) cnt_d = cnt_q + 7'd1;
    end
    // Only complete frames are accepted; a frame arriving while full is lost
    if (frame_end && (cnt_q == 7'd64) && !valid_q) begin
      data_d  = shift_q;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ss_q    <= 3'b111;
      sck_q   <= '0;
      sd_q    <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ss_q    <= {ss_q[1:0], ss_i};
      sck_q   <= {sck_q[1:0], sck_i};
      sd_q    <= {sd_q[0], sd_i};
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign sack_o  = valid_q;
endmodule

// Serial transmitter: shifts one word out at CLK/2 and stays busy until acknowledged.
module spi_master (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [63:0] data_i,
  input  logic        wr_i,
  output logic        busy_o,
  output logic        ss_o,
  output logic        sck_o,
  output logic        sd_o,
  input  logic        sack_i
);
  typedef enum logic [1:0] {StIdle, StShift, StEnd, StWaitAck} state_e;

  state_e      state_q, state_d;
  logic [63:0] sh_q, sh_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        phase_q, phase_d;
  logic        ss_q, ss_d, sck_q, sck_d, sd_q, sd_d;
  logic [1:0]  sack_q;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    ss_d    = ss_q;
    sck_d   = sck_q;
    sd_d    = sd_q;
    unique case (state_q)
      StIdle: begin
        if (wr_i) begin
          sh_d    = data_i;
          cnt_d   = '0;
          phase_d = 1'b0;
          ss_d    = 1'b0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (!phase_q) begin
          sck_d   = 1'b0;
          sd_d    = sh_q[63];
          phase_d = 1'b1;
        end else begin
          sck_d   = 1'b1;
          sh_d    = {sh_q[62:0], 1'b0};
          phase_d = 1'b0;
          cnt_d   = cnt_q + 6'd1;
          if (cnt_q == 6'd63) state_d = StEnd;
        end
      end
      StEnd: begin
        sck_d   = 1'b0;
        ss_d    = 1'b1;
        state_d = StWaitAck;
      end
      StWaitAck: begin
        if (sack_q[1]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      sh_q    <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      ss_q    <= 1'b1;
      sck_q   <= 1'b0;
      sd_q    <= 1'b0;
      sack_q  <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      ss_q    <= ss_d;
      sck_q   <= sck_d;
      sd_q    <= sd_d;
      sack_q  <= {sack_q[0], sack_i};
    end
  end

  assign busy_o = (state_q != StIdle);
  assign ss_o   = ss_q;
  assign sck_o  = sck_q;
  assign sd_o   = sd_q;
endmodule

module trans_test_echo #(
  parameter logic [63:0] ECHO_MASK   = 64'h0,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             SPI_RX_SS,
  input  logic             SPI_RX_SCK,
  input  logic             SPI_RX_SD,
  output logic             SPI_RX_SACK,
  output logic             SPI_TX_SS,
  output logic             SPI_TX_SCK,
  output logic             SPI_TX_SD,
  input  logic             SPI_TX_SACK,
  output logic [CNT_W-1:0] WORD_CNT,
  output logic [CNT_W-1:0] DROP_CNT,
  output logic [63:0]      LAST_WORD,
  output logic             TIMEOUT
);
  typedef enum logic [2:0] {StIdle, StCapture, StAck, StWaitTx, StSend, StSettle} state_e;

  localparam logic [31:0] WaitLast = TIMEOUT_CYC - 32'd1;

  state_e            state_q, state_d;
  logic [63:0]       hold_q, hold_d, last_q, last_d;
  logic [31:0]       wait_q, wait_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d, dcnt_q, dcnt_d;
  logic              to_q, to_d;

  logic              rx_valid, rx_rd, tx_wr, tx_busy;
  logic [63:0]       rx_data, tx_data;

  spi_slave u_slave (
    .clk_i   (CLK),
    .rst_ni  (RESET_N),
    .ss_i    (SPI_RX_SS),
    .sck_i   (SPI_RX_SCK),
    .sd_i    (SPI_RX_SD),
    .sack_o  (SPI_RX_SACK),
    .data_o  (rx_data),
    .valid_o (rx_valid),
    .rd_i    (rx_rd)
  );

  spi_master u_master (
    .clk_i  (CLK),
    .rst_ni (RESET_N),
    .data_i (tx_data),
    .wr_i   (tx_wr),
    .busy_o (tx_busy),
    .ss_o   (SPI_TX_SS),
    .sck_o  (SPI_TX_SCK),
    .sd_o   (SPI_TX_SD),
    .sack_i (SPI_TX_SACK)
  );

  // hold_q may be reloaded while the master is still busy with the previous word, so once
  // written the master sees last_q, which only changes on the next WR.
  assign tx_data = (state_q == StWaitTx) ? hold_q : last_q;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    last_d  = last_q;
    wait_d  = wait_q;
    wcnt_d  = wcnt_q;
    dcnt_d  = dcnt_q;
    to_d    = to_q;
    rx_rd   = 1'b0;
    tx_wr   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rx_valid) state_d = StCapture;
      end
      StCapture: begin
        hold_d  = rx_data ^ ECHO_MASK;
        rx_rd   = 1'b1;
        wait_d  = '0;
        state_d = StAck;
      end
      StAck: begin
        state_d = StWaitTx;
      end
      StWaitTx: begin
        if (!tx_busy) begin
          tx_wr   = 1'b1;
          last_d  = hold_q;
          state_d = StSend;
        end else if ((TIMEOUT_CYC != 0) && (wait_q == WaitLast)) begin
          to_d    = 1'b1;
          dcnt_d  = dcnt_q + CNT_W'(1'b1);
          state_d = StIdle;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      StSend: begin
        state_d = StSettle;
      end
      // Extra cycle so a stale BUSY = 0 is not sampled before the master reacts to WR
      StSettle: begin
        wcnt_d  = wcnt_q + CNT_W'(1'b1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
      hold_q  <= '0;
      last_q  <= '0;
      wait_q  <= '0;
      wcnt_q  <= '0;
      dcnt_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      wait_q  <= wait_d;
      wcnt_q  <= wcnt_d;
      dcnt_q  <= dcnt_d;
      to_q    <= to_d;
    end
  end

  assign WORD_CNT  = wcnt_q;
  assign DROP_CNT  = dcnt_q;
  assign LAST_WORD = last_q;
  assign TIMEOUT   = to_q;
endmodule

// File: tb/tb_trans_test_echo.sv
// Bench for trans_test_echo. Instance A (no mask, 16-cycle timeout, 4-bit counters) is fully
// exercised; instance B (all-ones mask) shares the DE1 -> AD link and checks the mask path.
module tb_trans_test_echo;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RESET_N;
  logic        SPI_RX_SS, SPI_RX_SCK, SPI_RX_SD;
  logic        a_rx_sack, a_tx_ss, a_tx_sck, a_tx_sd, a_tx_sack;
  logic [3:0]  a_word_cnt, a_drop_cnt;
  logic [63:0] a_last;
  logic        a_timeout;
  logic        b_rx_sack, b_tx_ss, b_tx_sck, b_tx_sd, b_tx_sack;
  logic [31:0] b_word_cnt, b_drop_cnt;
  logic [63:0] b_last;
  logic        b_timeout;

  trans_test_echo #(.ECHO_MASK(64'h0), .TIMEOUT_CYC(16), .CNT_W(4)) dut_a (
    .CLK(CLK), .RESET_N(RESET_N),
    .SPI_RX_SS(SPI_RX_SS), .SPI_RX_SCK(SPI_RX_SCK), .SPI_RX_SD(SPI_RX_SD),
    .SPI_RX_SACK(a_rx_sack),
    .SPI_TX_SS(a_tx_ss), .SPI_TX_SCK(a_tx_sck), .SPI_TX_SD(a_tx_sd), .SPI_TX_SACK(a_tx_sack),
    .WORD_CNT(a_word_cnt), .DROP_CNT(a_drop_cnt), .LAST_WORD(a_last), .TIMEOUT(a_timeout)
  );

  trans_test_echo #(.ECHO_MASK(64'hFFFF_FFFF_FFFF_FFFF), .TIMEOUT_CYC(0), .CNT_W(32)) dut_b (
    .CLK(CLK), .RESET_N(RESET_N),
    .SPI_RX_SS(SPI_RX_SS), .SPI_RX_SCK(SPI_RX_SCK), .SPI_RX_SD(SPI_RX_SD),
    .SPI_RX_SACK(b_rx_sack),
    .SPI_TX_SS(b_tx_ss), .SPI_TX_SCK(b_tx_sck), .SPI_TX_SD(b_tx_sd), .SPI_TX_SACK(b_tx_sack),
    .WORD_CNT(b_word_cnt), .DROP_CNT(b_drop_cnt), .LAST_WORD(b_last), .TIMEOUT(b_timeout)
  );

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  int          rd_idx = 0;
  int          frames_a = 0;
  int          acks_a = 0;
  int          frames_b = 0;
  logic [63:0] rx_a_sh, rx_b_sh, b_rx_last;
  logic        ack_en = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // DE1 receiver model for instance A: collects returned words
  always begin
    @(negedge a_tx_ss);
    rx_a_sh = '0;
    for (int i = 0; i < 64; i++) begin
      @(posedge a_tx_sck);
      rx_a_sh = {rx_a_sh[62:0], a_tx_sd};
    end
    @(posedge a_tx_ss);
    got_q.push_back(rx_a_sh);
    frames_a++;
  end

  // DE1 acknowledge for instance A; withheld while ack_en is low
  initial begin
    a_tx_sack = 1'b0;
    forever begin
      @(negedge CLK);
      if (ack_en && (frames_a > acks_a)) begin
        acks_a++;
        a_tx_sack = 1'b1;
        repeat (4) @(negedge CLK);
        a_tx_sack = 1'b0;
      end
    end
  end

  // DE1 receiver model for instance B
  always begin
    @(negedge b_tx_ss);
    rx_b_sh = '0;
    for (int i = 0; i < 64; i++) begin
      @(posedge b_tx_sck);
      rx_b_sh = {rx_b_sh[62:0], b_tx_sd};
    end
    @(posedge b_tx_ss);
    b_rx_last = rx_b_sh;
    frames_b++;
  end

  // DE1 sender: one frame, 4 CLK per SCK period; push selects whether an echo is expected
  task automatic send_word(input logic [63:0] w, input bit push);
    int n;
    n = 0;
    repeat (4) @(negedge CLK);
    while (a_rx_sack && (n < 2000)) begin
      @(negedge CLK);
      n++;
    end
    check("rx_link_free", 64'(a_rx_sack), 64'd0);
    if (push) exp_q.push_back(w);
    SPI_RX_SS = 1'b0;
    repeat (2) @(negedge CLK);
    for (int b = 63; b >= 0; b--) begin
      SPI_RX_SD = w[b];
      repeat (2) @(negedge CLK);
      SPI_RX_SCK = 1'b1;
      repeat (2) @(negedge CLK);
      SPI_RX_SCK = 1'b0;
    end
    repeat (2) @(negedge CLK);
    SPI_RX_SS = 1'b1;
  endtask

  // Wait for all expected echoes, then compare them in order
  task automatic drain(input string tag);
    int n;
    logic [63:0] e, g;
    n = 0;
    while ((got_q.size() < rd_idx + exp_q.size()) && (n < 4000)) begin
      @(negedge CLK);
      n++;
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = (rd_idx < got_q.size()) ? got_q[rd_idx] : 64'bx;
      check(tag, g, e);
      rd_idx++;
    end
    repeat (8) @(negedge CLK);
    check({tag, "_count"}, 64'(got_q.size()), 64'(rd_idx));
  endtask

  task automatic wait_rd(input string tag);
    int n;
    n = 0;
    while (!dut_a.rx_rd && (n < 2000)) begin
      @(negedge CLK);
      n++;
    end
    check(tag, 64'(dut_a.rx_rd), 64'd1);
  endtask

  initial begin
    int n;
    int fb;
    SPI_RX_SS  = 1'b1;
    SPI_RX_SCK = 1'b0;
    SPI_RX_SD  = 1'b0;
    b_tx_sack  = 1'b1;
    RESET_N    = 1'b0;
    repeat (3) @(negedge CLK);

    // Reset state
    check("rst_word_cnt", 64'(a_word_cnt), 64'd0);
    check("rst_drop_cnt", 64'(a_drop_cnt), 64'd0);
    check("rst_last_word", a_last, 64'd0);
    check("rst_timeout", 64'(a_timeout), 64'd0);
    check("rst_rx_sack", 64'(a_rx_sack), 64'd0);
    check("rst_tx_ss", 64'(a_tx_ss), 64'd1);
    check("rst_b_rx_sack", 64'(b_rx_sack), 64'd0);
    check("rst_b_drop", 64'(b_drop_cnt), 64'd0);
    check("rst_b_timeout", 64'(b_timeout), 64'd0);
    RESET_N = 1'b1;
    @(negedge CLK);

    // Handshake timing on the first word: RD at t+1 only, WR at t+3 only
    send_word(64'd0, 1'b1);
    n = 0;
    while (!dut_a.rx_valid && (n < 100)) begin
      @(negedge CLK);
      n++;
    end
    check("hs_valid", 64'(dut_a.rx_valid), 64'd1);
    @(negedge CLK);
    check("hs_rd_t1", 64'({dut_a.rx_rd, dut_a.tx_wr}), 64'b10);
    @(negedge CLK);
    check("hs_t2", 64'({dut_a.rx_rd, dut_a.tx_wr}), 64'b00);
    @(negedge CLK);
    check("hs_wr_t3", 64'({dut_a.rx_rd, dut_a.tx_wr, dut_a.tx_busy}), 64'b010);
    @(negedge CLK);
    check("hs_wr_t4", 64'(dut_a.tx_wr), 64'd0);

    // Counter loopback
    for (int i = 1; i < 20; i++) send_word(64'(i), 1'b1);
    drain("echo_loop");
    check("loop_word_cnt", 64'(a_word_cnt), 64'd4);
    check("loop_drop_cnt", 64'(a_drop_cnt), 64'd0);
    check("loop_timeout", 64'(a_timeout), 64'd0);
    check("loop_last_word", a_last, 64'd19);

    // Masked echo on instance B; A echoes it unchanged
    fb = frames_b;
    send_word(64'h0123_4567_89AB_CDEF, 1'b1);
    drain("echo_plain");
    n = 0;
    while ((frames_b <= fb) && (n < 2000)) begin
      @(negedge CLK);
      n++;
    end
    check("mask_tx_word", b_rx_last, 64'hFEDC_BA98_7654_3210);
    check("mask_last_word", b_last, 64'hFEDC_BA98_7654_3210);
    check("mask_word_cnt", 64'(b_word_cnt), 64'd21);

    // Timeout: master left busy by a withheld acknowledge
    ack_en = 1'b0;
    send_word(64'hA5A5_5A5A_0F0F_F0F0, 1'b1);
    drain("echo_pre_to");
    send_word(64'hDEAD_BEEF_0000_0001, 1'b0);
    wait_rd("to_capture");
    n = 0;
    while (!a_timeout && (n < 100)) begin
      @(negedge CLK);
      n++;
    end
    check("to_latency", 64'(n), 64'd18);
    check("to_drop_cnt", 64'(a_drop_cnt), 64'd1);
    check("to_word_cnt", 64'(a_word_cnt), 64'd6);
    ack_en = 1'b1;
    send_word(64'h1111_2222_3333_4444, 1'b1);
    drain("echo_post_to");
    check("post_to_word_cnt", 64'(a_word_cnt), 64'd7);
    check("post_to_timeout", 64'(a_timeout), 64'd1);
    check("post_to_drop", 64'(a_drop_cnt), 64'd1);

    // Async reset in the middle of WAIT_TX
    ack_en = 1'b0;
    send_word(64'h7777_8888_9999_AAAA, 1'b1);
    drain("echo_pre_rst");
    send_word(64'hBBBB_CCCC_DDDD_EEEE, 1'b0);
    wait_rd("rst_capture");
    repeat (4) @(negedge CLK);
    #1 RESET_N = 1'b0;
    #1;
    check("arst_word_cnt", 64'(a_word_cnt), 64'd0);
    check("arst_drop_cnt", 64'(a_drop_cnt), 64'd0);
    check("arst_last_word", a_last, 64'd0);
    check("arst_timeout", 64'(a_timeout), 64'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    ack_en  = 1'b1;

    // 17 words after reset: echo works and the 4-bit counter wraps to 1
    send_word(64'd100, 1'b1);
    drain("echo_post_rst");
    check("post_rst_word_cnt", 64'(a_word_cnt), 64'd1);
    for (int i = 101; i < 117; i++) send_word(64'(i), 1'b1);
    drain("echo_wrap");
    check("wrap_word_cnt", 64'(a_word_cnt), 64'd1);
    check("wrap_timeout", 64'(a_timeout), 64'd0);
    check("wrap_drop_cnt", 64'(a_drop_cnt), 64'd0);
    check("wrap_last_word", a_last, 64'd116);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
